// File: rtl/board_io_ctrl.sv
// Board-level I/O conditioner: synchronised and debounced inputs with edge pulses,
// registered plain LEDs and phase-aligned per-channel PWM for RGB LEDs.
module board_io_ctrl #(
  parameter int unsigned NumLeds        = 4,
  parameter int unsigned NumRgb         = 4,
  parameter int unsigned NumInputs      = 8,
  parameter int unsigned DebounceCycles = 50000,
  parameter int unsigned PwmWidth       = 8,
  parameter int unsigned PwmPrescale    = 1,
  parameter bit          LedActiveLow   = 1'b0
) (
  input  logic                             clk_sys_i,
  input  logic                             rst_sys_ni,
  input  logic [NumInputs-1:0]             in_raw_i,
  output logic [NumInputs-1:0]             in_o,
  output logic [NumInputs-1:0]             in_rise_o,
  output logic [NumInputs-1:0]             in_fall_o,
  input  logic [NumLeds-1:0]               led_i,
  output logic [NumLeds-1:0]               led_o,
  input  logic                             pwm_en_i,
  input  logic [3*NumRgb*PwmWidth-1:0]     rgb_duty_i,
  output logic [3*NumRgb-1:0]              rgb_led_o
);

  localparam int unsigned NumCh = 3 * NumRgb;
  localparam int unsigned CntW  = $clog2(DebounceCycles + 1);
  localparam int unsigned PresW = (PwmPrescale > 1) ? $clog2(PwmPrescale) : 1;

  localparam logic [CntW-1:0]    CntMax  = CntW'(DebounceCycles - 1);
  localparam logic [PresW-1:0]   PresMax = PresW'(PwmPrescale - 1);
  localparam logic [NumLeds-1:0] LedOff  = {NumLeds{LedActiveLow}};
  localparam logic [NumCh-1:0]   RgbOff  = {NumCh{LedActiveLow}};

  // ---------------------------------------------------------------------------
  // Input synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic [NumInputs-1:0] sync1_q, sync2_q;
  logic [NumInputs-1:0] in_q, in_d;
  logic [NumInputs-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CntW-1:0]      cnt_q [NumInputs];
  logic [CntW-1:0]      cnt_d [NumInputs];

  always_comb begin
    in_d   = in_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      cnt_d[i] = '0;
      // Any return to the accepted level (a bounce) leaves the count cleared.
      if (sync2_q[i] != in_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          in_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      in_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int unsigned i = 0; i < NumInputs; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= in_raw_i;
      sync2_q <= sync1_q;
      in_q    <= in_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int unsigned i = 0; i < NumInputs; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign in_o      = in_q;
  assign in_rise_o = rise_q;
  assign in_fall_o = fall_q;

  // ---------------------------------------------------------------------------
  // Plain LEDs
  // ---------------------------------------------------------------------------
  logic [NumLeds-1:0] led_q;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      led_q <= LedOff;
    end else begin
      led_q <= led_i ^ LedOff;
    end
  end

  assign led_o = led_q;

  // ---------------------------------------------------------------------------
  // RGB PWM
  // ---------------------------------------------------------------------------
  logic [PresW-1:0]    presc_q, presc_d;
  logic [PwmWidth-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                en_q;
  logic [PwmWidth-1:0] shadow_q [NumCh];
  logic [NumCh-1:0]    rgb_q, rgb_d;
  logic [NumCh-1:0]    ch_on;
  logic                tick, run, period_start;

  // The first enabled cycle is itself a period start: counters stay at 0 and
  // the shadow duties load, so the first visible period is complete.
  assign run          = en_q & pwm_en_i;
  assign tick         = (presc_q == PresMax);
  assign period_start = (pwm_en_i & ~en_q) | (run & tick & (pwm_cnt_q == '1));

  always_comb begin
    presc_d   = '0;
    pwm_cnt_d = '0;
    if (run) begin
      presc_d   = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      ch_on[c] = (shadow_q[c] == '1) | (pwm_cnt_q < shadow_q[c]);
    end
    rgb_d = run ? (ch_on ^ RgbOff) : RgbOff;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      en_q      <= 1'b0;
      rgb_q     <= RgbOff;
      for (int unsigned c = 0; c < NumCh; c++) begin
        shadow_q[c] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      en_q      <= pwm_en_i;
      rgb_q     <= rgb_d;
      if (period_start) begin
        for (int unsigned c = 0; c < NumCh; c++) begin
          shadow_q[c] <= rgb_duty_i[c*PwmWidth +: PwmWidth];
        end
      end
    end
  end

  assign rgb_led_o = rgb_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Randomised scoreboard bench for board_io_ctrl: a window-based debounce model and a
// period/phase PWM model push expected outputs; a monitor pops and compares each cycle.
module tb_board_io_ctrl;

  localparam int unsigned NL     = 4;
  localparam int unsigned NR     = 2;
  localparam int unsigned NI     = 4;
  localparam int unsigned DEB    = 4;
  localparam int unsigned PW     = 3;
  localparam int unsigned PRE    = 2;
  localparam bit          AL     = 1'b1;
  localparam int unsigned NCH    = 3 * NR;
  localparam int unsigned PERIOD = PRE * (1 << PW);
  localparam int unsigned DMAX   = (1 << PW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NI-1:0]        in_raw = '0;
  logic [NI-1:0]        in_lvl, in_rise, in_fall;
  logic [NL-1:0]        led_in = '0;
  logic [NL-1:0]        led_pin;
  logic                 pwm_en = 1'b0;
  logic [NCH*PW-1:0]    duty = '0;
  logic [NCH-1:0]       rgb_pin;

  int n_checks = 0;
  int n_fail   = 0;

  board_io_ctrl #(
    .NumLeds       (NL),
    .NumRgb        (NR),
    .NumInputs     (NI),
    .DebounceCycles(DEB),
    .PwmWidth      (PW),
    .PwmPrescale   (PRE),
    .LedActiveLow  (AL)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .in_raw_i  (in_raw),
    .in_o      (in_lvl),
    .in_rise_o (in_rise),
    .in_fall_o (in_fall),
    .led_i     (led_in),
    .led_o     (led_pin),
    .pwm_en_i  (pwm_en),
    .rgb_duty_i(duty),
    .rgb_led_o (rgb_pin)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NI-1:0]  in_v;
    logic [NI-1:0]  rise;
    logic [NI-1:0]  fall;
    logic [NL-1:0]  led;
    logic [NCH-1:0] rgb;
  } exp_t;

  exp_t          exp_q[$];
  logic [NI-1:0] raw_hist[$];  // raw samples, oldest first; last DEB+2 edges
  logic [NI-1:0] m_in;
  bit            m_active;
  int            m_phase;      // cycles since the current PWM period began
  int            m_shadow[NCH];

  function automatic exp_t reset_rec();
    exp_t e;
    e.in_v = '0;
    e.rise = '0;
    e.fall = '0;
    e.led  = {NL{AL}};
    e.rgb  = {NCH{AL}};
    return e;
  endfunction

  task automatic model_reset();
    m_in = '0;
    raw_hist.delete();
    for (int i = 0; i < DEB + 2; i++) raw_hist.push_back('0);
    m_active = 0;
    m_phase  = 0;
    for (int c = 0; c < NCH; c++) m_shadow[c] = 0;
  endtask

  task automatic model_step();
    exp_t e;
    bool_t_dummy();
    raw_hist.push_back(in_raw);
    void'(raw_hist.pop_front());
    e.rise = '0;
    e.fall = '0;
    // Level flips once the DEB samples that reached the comparator (2 flops late)
    // all disagree with the accepted level.
    for (int b = 0; b < NI; b++) begin
      bit all_diff = 1;
      for (int j = 0; j < DEB; j++) if (raw_hist[j][b] == m_in[b]) all_diff = 0;
      if (all_diff) begin
        m_in[b] = ~m_in[b];
        if (m_in[b]) e.rise[b] = 1'b1;
        else         e.fall[b] = 1'b1;
      end
    end
    e.in_v = m_in;
    e.led  = led_in ^ {NL{AL}};
    for (int c = 0; c < NCH; c++) begin
      bit on = 0;
      if (m_active && pwm_en)
        on = (m_shadow[c] == DMAX) || ((m_phase / PRE) < m_shadow[c]);
      e.rgb[c] = on ^ AL;
    end
    if (!pwm_en) begin
      m_active = 0;
      m_phase  = 0;
    end else begin
      if (!m_active) begin
        m_active = 1;
        m_phase  = 0;
      end else begin
        m_phase = (m_phase + 1) % PERIOD;
      end
      if (m_phase == 0)
        for (int c = 0; c < NCH; c++) m_shadow[c] = int'(duty[c*PW +: PW]);
    end
    exp_q.push_back(e);
  endtask

  function automatic void bool_t_dummy();
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        if (clk) exp_q.push_back(reset_rec());
      end else begin
        model_step();
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("in_o", 32'(in_lvl), 32'(e.in_v));
        check("in_rise_o", 32'(in_rise), 32'(e.rise));
        check("in_fall_o", 32'(in_fall), 32'(e.fall));
        check("led_o", 32'(led_pin), 32'(e.led));
        check("rgb_led_o", 32'(rgb_pin), 32'(e.rgb));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive_slot();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_slot();
  endtask

  task automatic set_duty(input int c, input int v);
    duty[c*PW +: PW] = PW'(v);
  endtask

  task automatic async_reset_check();
    drive_slot();
    rst_n = 1'b0;
    #1;
    check("async_rst in_o", 32'(in_lvl), 32'h0);
    check("async_rst rise|fall", 32'(in_rise | in_fall), 32'h0);
    check("async_rst led_o", 32'(led_pin), 32'({NL{AL}}));
    check("async_rst rgb_led_o", 32'(rgb_pin), 32'({NCH{AL}}));
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      drive_slot();
      for (int b = 0; b < NI; b++)
        if ($urandom_range(0, 5) == 0) in_raw[b] = ~in_raw[b];
      if ($urandom_range(0, 3) == 0) led_in = NL'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        int v;
        case ($urandom_range(0, 3))
          0:       v = 0;
          1:       v = DMAX;
          default: v = $urandom_range(0, DMAX);
        endcase
        set_duty($urandom_range(0, NCH - 1), v);
      end
      if (pwm_en && $urandom_range(0, 59) == 0)      pwm_en = 1'b0;
      else if (!pwm_en && $urandom_range(0, 3) == 0) pwm_en = 1'b1;
    end
  endtask

  initial begin
    int found_at;
    int cnt_on[NCH];

    idle(3);
    rst_n = 1'b1;
    idle(DEB + 4);

    // Debounce latency: raw first sampled at edge offset 0, in_o expected at offset DEB+1.
    drive_slot();
    in_raw[0] = 1'b1;
    found_at = -1;
    for (int n = 0; n < 20 && found_at < 0; n++) begin
      @(posedge clk);
      #1;
      if (in_lvl[0]) begin
        found_at = n;
        check("rise with level", 32'(in_rise[0]), 32'h1);
      end
    end
    check("debounce latency", 32'(found_at), 32'(DEB + 1));

    // Bounce: 3 high, 1 low, then high; only the final stable run is accepted.
    drive_slot(); in_raw[1] = 1'b1;
    idle(2);
    drive_slot(); in_raw[1] = 1'b0;
    drive_slot(); in_raw[1] = 1'b1;
    idle(DEB + 4);

    // Duty coverage over one full period after settling.
    set_duty(0, 3);
    set_duty(1, 0);
    set_duty(2, DMAX);
    for (int c = 3; c < NCH; c++) set_duty(c, 5);
    pwm_en = 1'b1;
    idle(PERIOD * 2 + 5);
    for (int c = 0; c < NCH; c++) cnt_on[c] = 0;
    for (int n = 0; n < PERIOD; n++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) if (rgb_pin[c] == !AL) cnt_on[c]++;
    end
    check("pwm duty 3 on-cycles", 32'(cnt_on[0]), 32'(3 * PRE));
    check("pwm duty 0 on-cycles", 32'(cnt_on[1]), 32'h0);
    check("pwm duty max on-cycles", 32'(cnt_on[2]), 32'(PERIOD));
    check("pwm duty 5 on-cycles", 32'(cnt_on[3]), 32'(5 * PRE));

    // Mid-period duty change and disable, checked by the model.
    idle(5);
    drive_slot(); set_duty(0, 6);
    idle(PERIOD + 3);
    drive_slot(); pwm_en = 1'b0;
    idle(4);
    drive_slot(); pwm_en = 1'b1;
    idle(PERIOD);

    // Reset mid-debounce and mid-period.
    drive_slot(); in_raw[2] = ~in_raw[2];
    idle(2);
    async_reset_check();
    idle(DEB + 4);

    random_phase(3000);
    idle(DEB + 6);
    drive_slot();
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
